mono_multi: RTL and testbench
=============================

MONO_MULTI -- requirements
Module: mono_multi

Interface
REQ-001 Parameter N_CH, default 4: number of independent gate channels.
REQ-002 Parameter CNT_W, default 32: width of the per-channel cycle counter and of the timeout input.
REQ-003 Parameter TIMEOUT, default 500000000: gate length in cycles when timeout input is 0 (10 s at 50 MHz).
REQ-004 Port clock50  input  1  sole clock; all logic on rising edge.
REQ-005 Port rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port trig  input  N_CH  per-channel start request; rising edge (or level in HOLD mode) significant.
REQ-007 Port stop  input  N_CH  per-channel abort, level-sensitive.
REQ-008 Port mode  input  2  global mode: 00 ONESHOT (non-retriggerable), 01 RETRIG, 10 HOLD, 11 treated as RETRIG.
REQ-009 Port timeout  input  CNT_W  runtime gate length in cycles; 0 selects TIMEOUT.
REQ-010 Port gate  output  N_CH  per-channel registered control enable (not a modulated clock).
REQ-011 Port expired  output  N_CH  one-cycle pulse when a channel times out naturally.
REQ-012 Port busy  output  1  registered OR of all gate bits.

Function
REQ-013 Each channel SHALL be an independent FSM with states IDLE and RUN; gate[i] = 1 exactly in RUN.
REQ-014 Edge detect SHALL use a registered copy trig_q; edge[i] = trig[i] & ~trig_q[i].
REQ-015 IDLE, edge[i], stop[i]=0 -> RUN next cycle, cnt=0, limit latched (timeout, or TIMEOUT if timeout==0); latency trig edge -> gate high = 1 cycle.
REQ-016 RUN: cnt increments by 1 per cycle; at cnt == limit-1 -> IDLE next cycle, expired[i]=1 for that one cycle; gate therefore high exactly limit cycles.
REQ-017 limit SHALL be latched only on RUN entry (and on retrigger); timeout changes mid-run SHALL NOT affect the running channel.
REQ-018 limit == 1: gate high one cycle, expired pulse on the cycle gate falls.
REQ-019 ONESHOT: edges in RUN ignored.
REQ-020 RETRIG: edge in RUN resets cnt to 0 and relatches limit; edge coinciding with terminal count SHALL win (stay RUN, no expired pulse).
REQ-021 HOLD: while trig[i]=1 in RUN, cnt held at 0; countdown proceeds only after trig[i] falls.
REQ-022 stop[i]=1 forces IDLE next cycle, no expired pulse; stop dominates edge and terminal count in the same cycle; edge while stop high is consumed (no start after stop falls).
REQ-023 mode SHALL be sampled every cycle; a change affects the next decision, not the current count.
REQ-024 Counter SHALL never wrap: terminal compare precedes increment; cnt width CNT_W, limit up to 2^CNT_W-1.
REQ-025 busy SHALL equal OR of gate with same timing as gate.

Reset
REQ-026 rst_n=0 at a clock edge: all channels IDLE, gate=0, expired=0, busy=0, cnt=0, limit=0.
REQ-027 trig_q SHALL reset to all ones so a trig held high through reset release produces no edge.
REQ-028 Reset mid-RUN SHALL drop gate the following cycle with no expired pulse.

Verification
REQ-029 timeout=5, ONESHOT, trig[0] pulse at cycle 0 -> gate[0] high cycles 1..5, expired[0] at cycle 5, busy mirrors gate.
REQ-030 timeout=5, RETRIG, second edge at cycle 3 -> gate[0] high 1..8, single expired at cycle 8; same in ONESHOT -> gate 1..5.
REQ-031 timeout=0, TIMEOUT overridden to 10 -> gate 10 cycles; timeout changed 5->20 mid-run -> still 5 cycles.
REQ-032 HOLD, timeout=3, trig high cycles 0..9 -> gate high 1..12, expired at 12.
REQ-033 stop[1] at cycle 2 of run, simultaneous trig edge on channel 2 -> gate[1] low at 3, no expired[1]; channel 2 starts normally.
REQ-034 trig held high across rst_n release, and rst_n asserted mid-run -> no start after release; gate low next cycle, no expired.

Source files
------------

// File: rtl/mono_multi.sv
// Multi-channel monostable gate generator: each channel opens a registered gate for a
// programmable number of cycles after a trigger edge, with one-shot, retrigger and hold modes.
module mono_multi #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 500000000
) (
    input  logic             clock50,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  trig,
    input  logic [N_CH-1:0]  stop,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] timeout,
    output logic [N_CH-1:0]  gate,
    output logic [N_CH-1:0]  expired,
    output logic             busy
);

    typedef enum logic {StIdle, StRun} state_e;

    localparam logic [CNT_W-1:0] TimeoutDef = CNT_W'(TIMEOUT);

    logic [N_CH-1:0]  trig_q;
    logic [N_CH-1:0]  trig_rise;
    logic [N_CH-1:0]  run_d;
    logic             busy_q;
    logic             mode_retrig;
    logic             mode_hold;
    logic [CNT_W-1:0] new_limit;

    assign trig_rise   = trig & ~trig_q;
    // 11 behaves as RETRIG, so bit 0 alone selects retrigger.
    assign mode_retrig = mode[0];
    assign mode_hold   = (mode == 2'b10);
    assign new_limit   = (timeout == '0) ? TimeoutDef : timeout;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] limit_q, limit_d;
        logic             terminal;
        logic             expired_c;

        assign terminal = (cnt_q == (limit_q - 1'b1));

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            limit_d   = limit_q;
            expired_c = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (trig_rise[ch] && !stop[ch]) begin
                        state_d = StRun;
                        cnt_d   = '0;
                        limit_d = new_limit;
                    end
                end
                StRun: begin
                    // Priority: stop, retrigger, hold, terminal count, count.
                    if (stop[ch]) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (trig_rise[ch] && mode_retrig) begin
                        cnt_d   = '0;
                        limit_d = new_limit;
                    end else if (mode_hold && trig[ch]) begin
                        cnt_d = '0;
                    end else if (terminal) begin
                        state_d   = StIdle;
                        cnt_d     = '0;
                        expired_c = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
            // A reset cutting a run short is not a natural timeout.
            if (!rst_n) begin
                expired_c = 1'b0;
            end
        end

        always_ff @(posedge clock50) begin
            if (!rst_n) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                limit_q <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                limit_q <= limit_d;
            end
        end

        assign gate[ch]    = (state_q == StRun);
        assign expired[ch] = expired_c;
        assign run_d[ch]   = (state_d == StRun);
    end

    always_ff @(posedge clock50) begin
        if (!rst_n) begin
            trig_q <= '1;
            busy_q <= 1'b0;
        end else begin
            trig_q <= trig;
            busy_q <= |run_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_mono_multi.sv
// Directed self-checking bench for mono_multi; cycle c starts just after the c-th rising edge
// of a scenario, inputs are driven at edge+1 and outputs sampled at edge+2.
module tb_mono_multi;

    localparam int unsigned NCh  = 4;
    localparam int unsigned CntW = 32;

    logic            clock50 = 1'b0;
    logic            rst_n;
    logic [NCh-1:0]  trig;
    logic [NCh-1:0]  stop;
    logic [1:0]      mode;
    logic [CntW-1:0] timeout;
    logic [NCh-1:0]  gate;
    logic [NCh-1:0]  expired;
    logic            busy;

    int errors = 0;
    int checks = 0;

    mono_multi #(
        .N_CH   (NCh),
        .CNT_W  (CntW),
        .TIMEOUT(10)
    ) dut (
        .clock50(clock50),
        .rst_n  (rst_n),
        .trig   (trig),
        .stop   (stop),
        .mode   (mode),
        .timeout(timeout),
        .gate   (gate),
        .expired(expired),
        .busy   (busy)
    );

    always #5 clock50 = ~clock50;

    task automatic next_cycle();
        @(posedge clock50);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        trig    = '1;
        stop    = '0;
        mode    = 2'b00;
        timeout = 32'd5;
        repeat (2) next_cycle();
        #1;
        checks++;
        if (gate !== 4'b0000 || expired !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: gate=%b expired=%b busy=%b, want 0000 0000 0", gate, expired,
                     busy);
        end
        // trig held high across release must not start anything.
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            #1;
            checks++;
            if (gate !== 4'b0000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_release_trig_high cyc %0d: gate=%b busy=%b, want 0000 0",
                         c, gate, busy);
            end
        end
        trig = '0;
        repeat (2) next_cycle();
    endtask

    // Channel 0 pulses at cycle 0 and optionally at t2; gate expected high 1..last.
    task automatic test_pulse(input string name, input logic [1:0] md, input int to,
                              input int t2, input int last, input int ncyc);
        logic [3:0] eg, ee;
        mode    = md;
        timeout = CntW'(to);
        for (int c = 0; c < ncyc; c++) begin
            trig = (c == 0 || c == t2) ? 4'b0001 : 4'b0000;
            #1;
            eg = {3'b000, (c >= 1 && c <= last)};
            ee = {3'b000, (c == last)};
            checks++;
            if (gate !== eg || expired !== ee || busy !== eg[0]) begin
                errors++;
                $display("FAIL %s cyc %0d: gate=%b expired=%b busy=%b, want %b %b %b", name, c,
                         gate, expired, busy, eg, ee, eg[0]);
            end
            next_cycle();
        end
        trig = '0;
    endtask

    task automatic test_timeout_change();
        logic [3:0] eg, ee;
        mode    = 2'b00;
        timeout = 32'd5;
        for (int c = 0; c < 9; c++) begin
            trig = (c == 0) ? 4'b0001 : 4'b0000;
            if (c == 2) timeout = 32'd20;
            #1;
            eg = {3'b000, (c >= 1 && c <= 5)};
            ee = {3'b000, (c == 5)};
            checks++;
            if (gate !== eg || expired !== ee || busy !== eg[0]) begin
                errors++;
                $display("FAIL timeout_change cyc %0d: gate=%b expired=%b busy=%b, want %b %b %b",
                         c, gate, expired, busy, eg, ee, eg[0]);
            end
            next_cycle();
        end
        timeout = 32'd5;
    endtask

    task automatic test_hold();
        logic [3:0] eg, ee;
        mode    = 2'b10;
        timeout = 32'd3;
        for (int c = 0; c < 15; c++) begin
            trig = (c <= 9) ? 4'b0001 : 4'b0000;
            #1;
            eg = {3'b000, (c >= 1 && c <= 12)};
            ee = {3'b000, (c == 12)};
            checks++;
            if (gate !== eg || expired !== ee || busy !== eg[0]) begin
                errors++;
                $display("FAIL hold cyc %0d: gate=%b expired=%b busy=%b, want %b %b %b", c, gate,
                         expired, busy, eg, ee, eg[0]);
            end
            next_cycle();
        end
        trig = '0;
    endtask

    task automatic test_stop();
        logic [3:0] eg, ee;
        mode    = 2'b00;
        timeout = 32'd5;
        for (int c = 0; c < 10; c++) begin
            trig    = '0;
            stop    = '0;
            trig[1] = (c == 0);
            trig[2] = (c == 2);
            trig[3] = (c >= 2 && c <= 6);
            stop[1] = (c == 2);
            stop[3] = (c >= 2 && c <= 3);
            #1;
            eg = {1'b0, (c >= 3 && c <= 7), (c >= 1 && c <= 2), 1'b0};
            ee = {1'b0, (c == 7), 2'b00};
            checks++;
            if (gate !== eg || expired !== ee || busy !== (|eg)) begin
                errors++;
                $display("FAIL stop cyc %0d: gate=%b expired=%b busy=%b, want %b %b %b", c, gate,
                         expired, busy, eg, ee, |eg);
            end
            next_cycle();
        end
        trig = '0;
        stop = '0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] eg, ee;
        mode    = 2'b00;
        timeout = 32'd5;
        for (int c = 0; c < 13; c++) begin
            trig = (c == 0 || c == 6) ? 4'b0001 : 4'b0000;
            #1;
            eg = {3'b000, ((c >= 1 && c <= 5) || (c >= 7 && c <= 11))};
            ee = {3'b000, (c == 5 || c == 11)};
            checks++;
            if (gate !== eg || expired !== ee || busy !== eg[0]) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: gate=%b expired=%b busy=%b, want %b %b %b",
                         c, gate, expired, busy, eg, ee, eg[0]);
            end
            next_cycle();
        end
        trig = '0;
    endtask

    task automatic test_reset_mid_run();
        logic [3:0] eg;
        mode    = 2'b00;
        timeout = 32'd5;
        for (int c = 0; c < 8; c++) begin
            trig  = (c == 0) ? 4'b0001 : 4'b0000;
            rst_n = (c != 2);
            #1;
            eg = {3'b000, (c >= 1 && c <= 2)};
            checks++;
            if (gate !== eg || expired !== 4'b0000 || busy !== eg[0]) begin
                errors++;
                $display("FAIL reset_mid_run cyc %0d: gate=%b expired=%b busy=%b, want %b 0000 %b",
                         c, gate, expired, busy, eg, eg[0]);
            end
            next_cycle();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_pulse("oneshot", 2'b00, 5, -1, 5, 8);
        test_pulse("oneshot_ignore_edge", 2'b00, 5, 3, 5, 8);
        test_pulse("retrig", 2'b01, 5, 3, 8, 11);
        test_pulse("retrig_mode11", 2'b11, 5, 3, 8, 11);
        test_pulse("retrig_at_terminal", 2'b01, 5, 5, 10, 13);
        test_pulse("default_timeout", 2'b00, 0, -1, 10, 13);
        test_pulse("limit_one", 2'b00, 1, -1, 1, 4);
        test_timeout_change();
        test_hold();
        test_stop();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
